uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between N_SRC message sources, with round-robin arbitration at message granularity.
- Sits between the message generators (hello-style ROM streamers, debug dumpers) and the UART TX byte interface (data/req/cts/idle).
- A granted source holds the transmitter until its last byte is accepted and the line returns idle. Only then is the next source chosen.

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular share of one UART TX among N_SRC sources; 1 ARB cycle per message, bytes
// pass combinationally while i_cts is high and sources hold on no-ack. UART_ARB_TIMEOUT_EN adds a stall abort.
module uart_tx_arbiter #(
  parameter int N_SRC          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 i_rstn,
  input  logic [N_SRC-1:0]     i_src_req,
  input  logic [N_SRC*8-1:0]   i_src_data,
  input  logic [N_SRC-1:0]     i_src_last,
  output logic [N_SRC-1:0]     o_src_ack,
  output logic [N_SRC-1:0]     o_grant,
  input  logic                 i_cts,
  input  logic                 i_idle,
  output logic [7:0]           o_data,
  output logic                 o_req,
  output logic                 o_busy,
  output logic                 o_abort
);
  localparam int IW = $clog2(N_SRC);

  typedef enum logic [1:0] {ARB, SEND, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   sum;
  logic          g_req, g_last, accept, abort;
  logic [7:0]    g_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Scan offsets high to low so the requester nearest rr+1 is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, rr_q} + (IW+1)'(i) + (IW+1)'(1);
      if (sum >= (IW+1)'(N_SRC)) sum = sum - (IW+1)'(N_SRC);
      if (i_src_req[sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[IW-1:0];
      end
    end
  end

  assign g_req  = i_src_req[rr_q];
  assign g_last = i_src_last[rr_q];
  assign g_data = i_src_data[{rr_q, 3'b000} +: 8];

  assign o_req     = (state_q == SEND) && g_req;
  assign o_data    = (state_q == SEND) ? g_data : 8'h00;
  assign accept    = o_req && i_cts;
  assign o_src_ack = accept ? (N_SRC'(1) << rr_q) : '0;
  assign o_grant   = (state_q != ARB) ? (N_SRC'(1) << rr_q) : '0;
  assign o_busy    = (state_q != ARB);
  assign o_abort   = abort;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    abort   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      ARB: begin
        if (pick_vld) begin
          rr_d    = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept && g_last) state_d = DRAIN;
`ifdef UART_ARB_TIMEOUT_EN
        // Only an absent request counts as a stall; i_cts backpressure never aborts.
        if (!g_req) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            abort   = 1'b1;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      DRAIN: begin
        if (i_idle) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ARB;
      rr_q    <= IW'(N_SRC - 1);
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source byte queues feed the DUT, expected accepts are queued
// in hand-derived grant order and a negedge monitor pops and compares them on every ack.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } exp_t;

  logic           clock = 1'b0;
  logic           i_rstn = 1'b0;
  logic [N-1:0]   i_src_req = '0;
  logic [N*8-1:0] i_src_data = '0;
  logic [N-1:0]   i_src_last = '0;
  logic [N-1:0]   o_src_ack, o_grant;
  logic           i_cts = 1'b1;
  logic           i_idle = 1'b1;
  logic [7:0]     o_data;
  logic           o_req, o_busy, o_abort;

  int total = 0;
  int bad   = 0;

  logic [8:0]   srcq [N][$];
  exp_t         expq [$];
  logic [N-1:0] ack_s = '0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .i_rstn     (i_rstn),
    .i_src_req  (i_src_req),
    .i_src_data (i_src_data),
    .i_src_last (i_src_last),
    .o_src_ack  (o_src_ack),
    .o_grant    (o_grant),
    .i_cts      (i_cts),
    .i_idle     (i_idle),
    .o_data     (o_data),
    .o_req      (o_req),
    .o_busy     (o_busy),
    .o_abort    (o_abort)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic last, input bit expect_ack);
    exp_t e;
    srcq[k].push_back({last, d});
    if (expect_ack) begin
      e.idx = 2'(k);
      e.dat = d;
      expq.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while ((expq.size() != 0 || o_busy) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_done"}, 32'(n < budget), 32'd1);
  endtask

  // Source model: a byte is retired only after the monitor saw its ack.
  always begin
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) begin
      if (ack_s[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      if (srcq[k].size() > 0) begin
        i_src_req[k]        = 1'b1;
        i_src_data[k*8 +: 8] = srcq[k][0][7:0];
        i_src_last[k]       = srcq[k][0][8];
      end else begin
        i_src_req[k]        = 1'b0;
        i_src_data[k*8 +: 8] = 8'h00;
        i_src_last[k]       = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    ack_s = o_src_ack;
    if (o_src_ack != '0) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack ack=%b data=%h required=none t=%0t", o_src_ack, o_data, $time);
      end else begin
        e = expq.pop_front();
        chk("ack_grant_data", {16'h0, o_src_ack, o_grant, o_data},
            {16'h0, 4'(1 << e.idx), 4'(1 << e.idx), e.dat});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_outs", {o_src_ack, o_grant, o_data, o_req, o_busy, o_abort}, 32'd0);
    i_rstn = 1'b1;
    @(negedge clock);
    chk("rst_release_outs", {o_src_ack, o_grant, o_data, o_req, o_busy, o_abort}, 32'd0);

    // src1 three-byte message, slow idle
    i_idle = 1'b0;
    push(1, 8'h41, 1'b0, 1'b1);
    push(1, 8'h42, 1'b0, 1'b1);
    push(1, 8'h43, 1'b1, 1'b1);
    @(negedge clock);
    chk("t1_arb_grant", {o_grant, o_req}, 32'd0);
    @(negedge clock);
    chk("t1_grant", {o_grant, o_req, o_busy}, {4'b0010, 1'b1, 1'b1});
    repeat (3) @(negedge clock);
    chk("t1_consecutive", expq.size(), 32'd0);
    chk("t1_drain", {o_busy, o_req, o_grant}, {1'b1, 1'b0, 4'b0010});
    repeat (2) @(negedge clock);
    chk("t1_drain_hold", {o_busy, o_req, o_grant}, {1'b1, 1'b0, 4'b0010});
    i_idle = 1'b1;
    @(negedge clock);
    chk("t1_release", {o_busy, o_grant}, 32'd0);

    // cts stall mid-message on src2
    push(2, 8'h51, 1'b0, 1'b1);
    push(2, 8'h52, 1'b0, 1'b1);
    push(2, 8'h53, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 i_cts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t3_stall", {o_req, o_data, o_src_ack}, {1'b1, 8'h52, 4'b0000});
    end
    @(posedge clock);
    #1 i_cts = 1'b1;
    wait_idle("t3", 20);

    // src3 takes the pointer
    push(3, 8'h61, 1'b1, 1'b1);
    wait_idle("t3b", 20);

    // src0 beats src3 after src3; src0 re-request waits behind src3
    push(0, 8'h70, 1'b1, 1'b1);
    push(3, 8'h71, 1'b1, 1'b1);
    push(0, 8'h72, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    chk("t4_drain_no_handoff", {o_req, o_grant, o_busy}, {1'b0, 4'b0001, 1'b1});
    @(negedge clock);
    chk("t4_arb_gap", {o_busy, o_grant}, 32'd0);
    @(negedge clock);
    chk("t4_src3_next", o_grant, 32'b1000);
    wait_idle("t4", 30);

    // Async reset after second byte of a four-byte src0 message
    push(0, 8'h80, 1'b0, 1'b1);
    push(0, 8'h81, 1'b0, 1'b1);
    push(0, 8'h82, 1'b0, 1'b0);
    push(0, 8'h83, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3 i_rstn = 1'b0;
    #1;
    chk("t5_async_rst", {o_req, o_grant, o_busy, o_src_ack}, 32'd0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    repeat (2) @(negedge clock);
    chk("t5_no_extra_ack", expq.size(), 32'd0);
    i_rstn = 1'b1;
    @(negedge clock);
    chk("t5_after_release", {o_busy, o_grant, o_req}, 32'd0);

    // Round robin across all sources from reset pointer: 0,1,2,3,0,1,2,3
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++)
        push(k, 8'(8'h10 * (k + 1) + r), 1'b1, 1'b1);
    wait_idle("t2", 60);

    // Stalled src1 after one non-last byte
    push(1, 8'h90, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (7) @(negedge clock);
    chk("t6_no_early_abort", o_abort, 32'd0);
    @(negedge clock);
    chk("t6_abort", {o_abort, o_busy, o_grant}, {1'b1, 1'b1, 4'b0010});
    @(negedge clock);
    chk("t6_drain", {o_abort, o_busy, o_grant}, {1'b0, 1'b1, 4'b0010});
    @(negedge clock);
    chk("t6_arb", {o_abort, o_busy, o_grant}, 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("t6_hold", {o_abort, o_busy, o_grant}, {1'b0, 1'b1, 4'b0010});
    end
    push(1, 8'h91, 1'b1, 1'b1);
`endif
    wait_idle("t6", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
